// File: rtl/pulse_train_ctrl.sv
// ============================================================================
// Module   : pulse_train_ctrl
// Purpose  : Generates a train of count pulses, each high_len cycles high and
//            max(low_len,1) cycles low, with abort and a completion strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_ctrl #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] high_len,
    input  logic [W-1:0] low_len,
    input  logic [W-1:0] count,
    output logic         signal,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] emitted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_high_len;
    logic [W-1:0] r_low_len;
    logic [W-1:0] r_count;
    logic [W-1:0] r_phase;
    logic [W-1:0] w_low_m1;

    // A zero low length is stretched to a single cycle.
    assign w_low_m1 = (r_low_len == '0) ? '0 : r_low_len - 1'b1;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_count    <= '0;
            r_phase    <= '0;
            signal     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            emitted    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    signal <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    if (start && !abort) begin
                        r_high_len <= high_len;
                        r_low_len  <= low_len;
                        r_count    <= count;
                        if (count == '0 || high_len == '0) begin
                            r_state <= S_DONE;
                            emitted <= '0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_HIGH;
                            r_phase <= high_len - 1'b1;
                            emitted <= {{(W-1){1'b0}}, 1'b1};
                            signal  <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        signal  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (r_phase != '0) begin
                        r_phase <= r_phase - 1'b1;
                    end else if (emitted == r_count) begin
                        r_state <= S_DONE;
                        signal  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state <= S_LOW;
                        r_phase <= w_low_m1;
                        signal  <= 1'b0;
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_phase != '0) begin
                        r_phase <= r_phase - 1'b1;
                    end else begin
                        r_state <= S_HIGH;
                        r_phase <= r_high_len - 1'b1;
                        emitted <= emitted + 1'b1;
                        signal  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    signal  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/pulse_train_ctrl.md
PULSE_TRAIN_CTRL -- requirements
Module: pulse_train_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, setting the width of all length/count fields.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to launch a pulse train; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, terminates an active train.
REQ-006 SHALL have port high_len, input, W, high-phase length in clock cycles.
REQ-007 SHALL have port low_len, input, W, low-phase length in clock cycles.
REQ-008 SHALL have port count, input, W, number of pulses in the train.
REQ-009 SHALL have port signal, output, 1, registered pulse-train output.
REQ-010 SHALL have port busy, output, 1, high while in HIGH or LOW state.
REQ-011 SHALL have port done, output, 1, one-cycle completion strobe.
REQ-012 SHALL have port emitted, output, W, pulses started in the current/last train.

Function
REQ-013 SHALL implement states IDLE, HIGH, LOW, DONE; all outputs registered, driven from state/counters.
REQ-014 In IDLE with start=1 at an edge: SHALL latch high_len, low_len, count into internal registers; inputs not sampled again until the next IDLE launch.
REQ-015 Launch with latched count=0 or high_len=0: SHALL go to DONE (no pulse, emitted=0).
REQ-016 Otherwise launch: SHALL go to HIGH; signal=1 from the first cycle after the launch edge; emitted becomes 1.
REQ-017 HIGH SHALL last exactly high_len cycles with signal=1.
REQ-018 At end of HIGH with pulses remaining: SHALL enter LOW for max(low_len,1) cycles, signal=0; low_len=0 treated as 1.
REQ-019 At end of LOW: SHALL re-enter HIGH and increment emitted.
REQ-020 At end of the HIGH phase of pulse number count: SHALL go to DONE (no trailing LOW).
REQ-021 DONE SHALL last exactly one cycle with done=1, signal=0, busy=0, then go to IDLE.
REQ-022 busy SHALL be 1 exactly in HIGH and LOW; signal SHALL be 1 only in HIGH.
REQ-023 start while not IDLE (including in DONE) SHALL be ignored.
REQ-024 abort=1 at an edge in HIGH or LOW SHALL go to IDLE next cycle: signal=0, busy=0, done stays 0, emitted holds.
REQ-025 abort and end-of-train at the same edge: abort SHALL win (no done).
REQ-026 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE: SHALL stay in IDLE.
REQ-027 emitted SHALL clear to 0 on each launch and hold its value in IDLE; count=2^W-1 SHALL complete without counter wrap.
REQ-028 Period per pulse SHALL be high_len + max(low_len,1) cycles; total busy time = count*high_len + (count-1)*max(low_len,1).

Reset
REQ-029 clear=0 SHALL immediately (asynchronously) force IDLE, signal=0, busy=0, done=0, emitted=0, latched registers=0.
REQ-030 clear asserted mid-train SHALL abort with no done strobe; first edge after release SHALL be able to launch.

Verification
REQ-031 high_len=3, low_len=2, count=3, start 1 cycle -> signal pattern 111 00 111 00 111, busy 13 cycles, done 1 cycle after, emitted=3.
REQ-032 count=0 (or high_len=0), start -> signal never 1, busy never 1, done=1 one cycle after launch edge.
REQ-033 high_len=2, low_len=0, count=2 -> signal 11 0 11 (low treated as 1 cycle), then done.
REQ-034 high_len=4, low_len=4, count=5, abort during pulse 2 HIGH -> signal 0 next cycle, no done, emitted=2, IDLE.
REQ-035 start re-pulsed and high_len changed mid-train -> train timing unchanged from latched values.
REQ-036 clear=0 asynchronously mid-HIGH -> signal/busy 0 without waiting for a clock edge; new start after release runs correctly.
